// File: rtl/act_lut_pkg.sv
// Shared definitions for the tanh/sigmoid interpolation pipeline: func encodings, the
// default tables (DATA_W=8, ADDR_W=4, 4 fraction bits) and the output saturation helper.
package act_lut_pkg;

    localparam int LUT_DATA_W = 8;
    localparam int LUT_ADDR_W = 4;
    localparam int LUT_DEPTH  = 2 ** LUT_ADDR_W;
    localparam int LUT_SUM_W  = LUT_DATA_W + 2;

    localparam logic FUNC_TANH    = 1'b0;
    localparam logic FUNC_SIGMOID = 1'b1;

    typedef logic signed [LUT_DATA_W-1:0] lut_entry_t;

    // Indexed by the raw segment bits; entries 8..15 hold the negative segments -8..-1.
    localparam lut_entry_t TANH_TABLE [LUT_DEPTH] = '{
        8'h00, 8'h0C, 8'h0F, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF1, 8'hF4
    };

    localparam lut_entry_t SIGMOID_TABLE [LUT_DEPTH] = '{
        8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h10, 8'h10, 8'h10, 8'h10,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04
    };

    function automatic lut_entry_t saturate(input logic signed [LUT_SUM_W-1:0] v);
        logic signed [LUT_SUM_W-1:0] max_v;
        logic signed [LUT_SUM_W-1:0] min_v;
        max_v = LUT_SUM_W'((2 ** (LUT_DATA_W - 1)) - 1);
        min_v = LUT_SUM_W'(-(2 ** (LUT_DATA_W - 1)));
        if (v > max_v) begin
            saturate = max_v[LUT_DATA_W-1:0];
        end else if (v < min_v) begin
            saturate = min_v[LUT_DATA_W-1:0];
        end else begin
            saturate = v[LUT_DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/act_lut_rom.sv
// Two-function activation table with independent base/next read ports.
// Build with ACT_LUT_INTERP_WR_EN to make the tables writable (reset restores the defaults).
module act_lut_rom
    import act_lut_pkg::*;
(
`ifdef ACT_LUT_INTERP_WR_EN
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  wfunc_i,
    input  logic [LUT_ADDR_W-1:0] waddr_i,
    input  lut_entry_t            wdata_i,
`endif
    input  logic                  func_i,
    input  logic [LUT_ADDR_W-1:0] base_addr_i,
    input  logic [LUT_ADDR_W-1:0] next_addr_i,
    output lut_entry_t            base_o,
    output lut_entry_t            next_o
);

    lut_entry_t tanh_tbl [LUT_DEPTH];
    lut_entry_t sig_tbl  [LUT_DEPTH];

`ifdef ACT_LUT_INTERP_WR_EN
    // Reads are combinational from the current contents, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tanh_tbl <= TANH_TABLE;
            sig_tbl  <= SIGMOID_TABLE;
        end else if (we_i) begin
            if (wfunc_i == FUNC_SIGMOID) begin
                sig_tbl[waddr_i] <= wdata_i;
            end else begin
                tanh_tbl[waddr_i] <= wdata_i;
            end
        end
    end
`else
    assign tanh_tbl = TANH_TABLE;
    assign sig_tbl  = SIGMOID_TABLE;
`endif

    always_comb begin
        base_o = '0;
        next_o = '0;
        case (func_i)
            FUNC_TANH: begin
                base_o = tanh_tbl[base_addr_i];
                next_o = tanh_tbl[next_addr_i];
            end
            FUNC_SIGMOID: begin
                base_o = sig_tbl[base_addr_i];
                next_o = sig_tbl[next_addr_i];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/act_lut_interp_pipe.sv
// Elastic 3-stage tanh/sigmoid piecewise-linear evaluator with tag pass-through.
// Optional macro ACT_LUT_INTERP_WR_EN adds a runtime table write port.
module act_lut_interp_pipe
    import act_lut_pkg::*;
#(
    parameter int DATA_W = LUT_DATA_W,
    parameter int ADDR_W = LUT_ADDR_W,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_func,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
`ifdef ACT_LUT_INTERP_WR_EN
    output logic [TAG_W-1:0]         out_tag,
    input  logic                     lut_we,
    input  logic                     lut_func,
    input  logic [ADDR_W-1:0]        lut_addr,
    input  logic signed [DATA_W-1:0] lut_wdata
`else
    output logic [TAG_W-1:0]         out_tag
`endif
);

    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int PROD_W = DATA_W + FRAC_W + 1;
    localparam int SUM_W  = DATA_W + 2;
    localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'((2 ** (ADDR_W - 1)) - 1);

    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_func_q,  s1_func_d;
    logic [ADDR_W-1:0]        s1_idx_q,   s1_idx_d;
    logic [FRAC_W-1:0]        s1_frac_q,  s1_frac_d;
    logic [TAG_W-1:0]         s1_tag_q,   s1_tag_d;
    logic                     s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0] s2_base_q,  s2_base_d;
    logic signed [DATA_W:0]   s2_diff_q,  s2_diff_d;
    logic [FRAC_W-1:0]        s2_frac_q,  s2_frac_d;
    logic [TAG_W-1:0]         s2_tag_q,   s2_tag_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0]         out_tag_q,   out_tag_d;

    logic adv1, adv2, adv3;
    logic [ADDR_W-1:0]        next_idx;
    logic signed [DATA_W-1:0] rd_base, rd_next;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;

    // A stage may load when it is empty or its contents move on this cycle.
    assign adv3     = !out_valid_q || out_ready;
    assign adv2     = !s2_valid_q || adv3;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // The most positive segment clamps to itself instead of wrapping to the most negative one.
    assign next_idx = (s1_idx_q == TOP_IDX) ? s1_idx_q : s1_idx_q + ADDR_W'(1);

    act_lut_rom u_rom (
`ifdef ACT_LUT_INTERP_WR_EN
        .clk_i       (clk),
        .rst_i       (rst),
        .we_i        (lut_we),
        .wfunc_i     (lut_func),
        .waddr_i     (lut_addr),
        .wdata_i     (lut_wdata),
`endif
        .func_i      (s1_func_q),
        .base_addr_i (s1_idx_q),
        .next_addr_i (next_idx),
        .base_o      (rd_base),
        .next_o      (rd_next)
    );

    assign prod = PROD_W'(s2_diff_q) * PROD_W'($signed({1'b0, s2_frac_q}));
    assign sum  = SUM_W'(s2_base_q) + SUM_W'(prod >>> FRAC_W);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_func_d   = s1_func_q;
        s1_idx_d    = s1_idx_q;
        s1_frac_d   = s1_frac_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_base_d   = s2_base_q;
        s2_diff_d   = s2_diff_q;
        s2_frac_d   = s2_frac_q;
        s2_tag_d    = s2_tag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_func_d = in_func;
                s1_idx_d  = in_data[DATA_W-1 -: ADDR_W];
                s1_frac_d = in_data[FRAC_W-1:0];
                s1_tag_d  = in_tag;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_base_d = rd_base;
                s2_diff_d = (DATA_W + 1)'(rd_next) - (DATA_W + 1)'(rd_base);
                s2_frac_d = s1_frac_q;
                s2_tag_d  = s1_tag_q;
            end
        end
        if (adv3) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = saturate(sum);
                out_tag_d  = s2_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_func_q   <= 1'b0;
            s1_idx_q    <= '0;
            s1_frac_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_base_q   <= '0;
            s2_diff_q   <= '0;
            s2_frac_q   <= '0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_func_q   <= s1_func_d;
            s1_idx_q    <= s1_idx_d;
            s1_frac_q   <= s1_frac_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_base_q   <= s2_base_d;
            s2_diff_q   <= s2_diff_d;
            s2_frac_q   <= s2_frac_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: doc/act_lut_interp_pipe.md
Name: act_lut_interp_pipe

Overview:
- Pipelined, parametrised successor to the single-function 8-bit combinational tanh LUT/interpolator used in the neural-network layers.
- Evaluates tanh or sigmoid per transaction using piecewise-linear interpolation between 2^ADDR_W LUT entries.
- Adds valid/ready flow control, 3-stage pipelining, output saturation and a pass-through tag.
- Sits between a layer's MAC/accumulator output and the next layer's input.

Parameters:
- DATA_W, 8: signed fixed-point width of input and output.
- ADDR_W, 4: LUT index bits, taken from the top of the input. FRAC_W = DATA_W-ADDR_W is the interpolation fraction width.
- TAG_W, 4: width of the sideband tag carried alongside each sample.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  DATA_W  signed pre-activation value z.
- in_func  in  1  0 = tanh, 1 = sigmoid.
- in_tag  in  TAG_W  opaque tag, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed activation result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: out_valid=0, out_data=0, out_tag=0, all stage-valid flags 0, in_ready=1 in the cycle after reset. rst during operation flushes every in-flight sample without producing output.
- Transfer rule: a transfer happens when valid&&ready on a port.
- Elastic pipeline: stage k loads when it is empty or stage k+1 loads/drains in the same cycle. in_ready = !s1_valid || s1 advancing.
- in_ready must not depend combinationally on in_valid.
- Latency is 3 cycles from input transfer to out_valid with no backpressure. Throughput is 1 sample per cycle while out_ready=1.
- While out_valid=1 && out_ready=0, out_data and out_tag are held stable and no sample is lost or duplicated.
- S1: idx = in_data[DATA_W-1 -: ADDR_W], treated as a raw unsigned index. frac = in_data[FRAC_W-1:0], zero-extended. Registers func, idx, frac, tag.
- S2: reads base = LUT_func[idx] and next = LUT_func[succ(idx)].
  - succ is the successor in signed order: idx+1 mod 2^ADDR_W.
  - Exception: for idx = 2^(ADDR_W-1)-1 (most positive segment), next = base (clamp, no wrap to the most negative entry).
  - Registers base and diff = next-base, with diff DATA_W+1 bits signed.
- S3: y = base + ((diff*frac) >>> FRAC_W).
  - Product is DATA_W+FRAC_W+1 bits signed; the shift is arithmetic (floor).
  - The result is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before registering into out_data.
- LUT entries are fixed-point with FRAC_W fraction bits. Entry i is f(v_i), where v_i is the signed value of idx i shifted left by FRAC_W, rounded to nearest.
- Simultaneous input and output transfers in the same cycle are legal at full rate.

Optional Feature:
- Macro: ACT_LUT_INTERP_WR_EN.
- When defined, adds the ports lut_we (in, 1), lut_func (in, 1), lut_addr (in, ADDR_W) and lut_wdata (in, DATA_W).
  - The write lands at the clock edge.
  - A sample whose S2 read coincides with the write sees the old value.
  - rst restores the package default tables.
- When undefined, the LUTs are constant ROMs and the ports are absent.

Decomposition:
- Package act_lut_pkg holds:
  - func encoding constants (FUNC_TANH=0, FUNC_SIGMOID=1);
  - default tanh and sigmoid tables as localparam arrays for DATA_W=8, ADDR_W=4;
  - a saturate function.
- Other parameterisations require regenerating the package tables with the existing generator.
- One sub-module, act_lut_rom (two-function table, two read ports: base and next), instantiated in S2.

Test Plan:
- tanh, in_data 0x00/0x10/0x08, out_ready=1 -> out_data 0x00/0x0C/0x06 after 3 cycles each, back-to-back at 1 per cycle.
- tanh, in_data 0xF0/0xF8 -> 0xF4 (-12) / 0xFA (-6). This exercises the idx 15 -> idx 0 successor.
- tanh, in_data 0x7F -> 0x10. Clamp at the top segment, no wrap to LUT[8].
- sigmoid, in_data 0x00 -> 0x08. Alternate in_func every cycle with tags 0..15 -> results and tags return in order, each function correct.
- Stream of 10 samples with out_ready toggled in a 1-0-0-1 pattern -> exactly 10 outputs, in order, values held stable while stalled; in_ready drops once all 3 stages are full.
- Assert rst with 3 samples in flight -> out_valid=0 on the next cycle, no stale outputs afterwards; the first post-reset sample returns in 3 cycles.
